// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter driving a shared 2:1 mux, bounded hold per grant; MUX_ARB_COUNT_EN adds gcnt0/gcnt1.
// Latency: req at edge N -> grant after edge N; no backpressure, requesters hold req until served.
module mux2to1_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
`ifdef MUX_ARB_COUNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef MUX_ARB_COUNT_EN
  ,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1
`endif
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              hold_full;
  logic              enter0, enter1;

  always_comb begin
    state_d   = state_q;
    hold_full = (hold_q == HOLD_LAST);
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (req0)     state_d = ST_GNT0;
        else if (req1)     state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (!req0)                     state_d = req1 ? ST_GNT1 : ST_IDLE;
        else if (req1 && hold_full)    state_d = ST_GNT1;
      end
      ST_GNT1: begin
        if (!req1)                     state_d = req0 ? ST_GNT0 : ST_IDLE;
        else if (req0 && hold_full)    state_d = ST_GNT0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter0 = (state_d == ST_GNT0) && (state_q != ST_GNT0);
  assign enter1 = (state_d == ST_GNT1) && (state_q != ST_GNT1);

  // Saturating hold count; only compared when the other side is waiting.
  always_comb begin
    hold_d = hold_q;
    if (enter0 || enter1)           hold_d = '0;
    else if (state_d == ST_IDLE)    hold_d = '0;
    else if (!hold_full)            hold_d = hold_q + HOLD_W'(1);
  end

  always_comb begin
    last_d = last_q;
    sel_d  = sel_q;
    if (enter0) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (enter1) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt0      = (state_q == ST_GNT0);
  assign gnt1      = (state_q == ST_GNT1);
  assign select    = sel_q;
  assign out       = sel_q ? in1 : in0;
  assign out_valid = gnt0 | gnt1;

`ifdef MUX_ARB_COUNT_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (enter0 && (gcnt0_q != {CNT_W{1'b1}})) gcnt0_q <= gcnt0_q + CNT_W'(1);
      if (enter1 && (gcnt1_q != {CNT_W{1'b1}})) gcnt1_q <= gcnt1_q + CNT_W'(1);
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`endif

endmodule
